// File: rtl/stream_xbar_pkg.sv
// Shared types and width helpers for the stream crossbar arbitration logic.
package stream_xbar_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // max(1, clog2(n)): keeps index/dest fields at least one bit wide.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping N-1 -> 0.
module stream_rr_picker #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                idx   = W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/stream_port_arbiter.sv
// Packet-level round-robin owner selection for one crossbar output port.
// Optional stall timeout with forced release: define STREAM_ARB_TIMEOUT_EN.
module stream_port_arbiter
    import stream_xbar_pkg::*;
#(
    parameter  int S_DATA_COUNT   = 2,
    parameter  int M_DATA_COUNT   = 3,
    parameter  int PORT_IDX       = 0,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int T_ID___WIDTH   = clog2_min1(S_DATA_COUNT),
    localparam int T_DEST_WIDTH   = clog2_min1(M_DATA_COUNT)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [T_DEST_WIDTH-1:0] s_dest_i [S_DATA_COUNT],
    input  logic [S_DATA_COUNT-1:0] s_valid_i,
    input  logic [S_DATA_COUNT-1:0] s_last_i,
    input  logic                    m_ready_i,
    output logic [T_ID___WIDTH-1:0] grant_o,
    output logic                    grant_valid_o,
    output logic                    timeout_o
);

    arb_state_t              state_q, state_d;
    logic [T_ID___WIDTH-1:0] grant_q, grant_d;
    logic [T_ID___WIDTH-1:0] ptr_q, ptr_d, ptr_adv, pick_ptr, pick_idx;
    logic                    gvalid_q, gvalid_d;
    logic [S_DATA_COUNT-1:0] req, owner_mask, cand;
    logic                    pick_found, beat, last_beat, force_rel, rel;

    always_comb begin
        for (int i = 0; i < S_DATA_COUNT; i++) begin
            req[i]        = s_valid_i[i] && (s_dest_i[i] == T_DEST_WIDTH'(PORT_IDX));
            owner_mask[i] = (grant_q == T_ID___WIDTH'(i));
        end
    end

    // A beat moves on the owner's stream when its valid and the port's ready
    // are both high in the same cycle; the packet ends on a beat with last set.
    assign beat      = s_valid_i[grant_q] && m_ready_i;
    assign last_beat = beat && s_last_i[grant_q];
    assign rel       = (state_q == LOCKED) && (last_beat || force_rel);
    assign ptr_adv   = (int'(grant_q) == S_DATA_COUNT - 1) ? '0 : grant_q + 1'b1;

    // On release the old owner sits out this pick and the search starts past it.
    assign cand     = rel ? (req & ~owner_mask) : req;
    assign pick_ptr = rel ? ptr_adv : ptr_q;

    stream_rr_picker #(
        .N (S_DATA_COUNT),
        .W (T_ID___WIDTH)
    ) u_picker (
        .req   (cand),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gvalid_d = gvalid_q;
        ptr_d    = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d  = pick_idx;
                    gvalid_d = 1'b1;
                    state_d  = LOCKED;
                end
            end
            LOCKED: begin
                if (rel) begin
                    ptr_d = ptr_adv;
                    if (pick_found) begin
                        grant_d = pick_idx;
                    end else begin
                        gvalid_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gvalid_q <= 1'b0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gvalid_q <= gvalid_d;
            ptr_q    <= ptr_d;
        end
    end

`ifdef STREAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] stall_cnt_q;
    logic             timeout_q;

    assign force_rel = (state_q == LOCKED) && !beat &&
                       (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if ((state_q == LOCKED) && !beat && !force_rel) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end else begin
                stall_cnt_q <= '0;
            end
            timeout_q <= force_rel;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign grant_o       = grant_q;
    assign grant_valid_o = gvalid_q;

endmodule

// File: tb/tb_stream_port_arbiter.sv
// Self-checking bench for stream_port_arbiter: vector table, directed sequences, random vs model.
module tb_stream_port_arbiter;

    localparam int S      = 4;
    localparam int M      = 3;
    localparam int P      = 1;
    localparam int TO_CYC = 8;
`ifdef STREAM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   dest [S];
    logic [S-1:0] valid;
    logic [S-1:0] last;
    logic         ready;
    logic [1:0]   grant;
    logic         gv;
    logic         to;

    always #5 clk = ~clk;

    stream_port_arbiter #(
        .S_DATA_COUNT   (S),
        .M_DATA_COUNT   (M),
        .PORT_IDX       (P),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .s_dest_i      (dest),
        .s_valid_i     (valid),
        .s_last_i      (last),
        .m_ready_i     (ready),
        .grant_o       (grant),
        .grant_valid_o (gv),
        .timeout_o     (to)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        valid = '0;
        last  = '0;
        ready = 1'b1;
        for (int i = 0; i < S; i++) dest[i] = 2'd0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic         rst;
        logic [S-1:0] valid;
        logic [S-1:0] last;
        logic [2*S-1:0] dest;
        logic         ready;
        logic         exp_gv;
        logic         chk_g;
        logic [1:0]   exp_g;
        logic         exp_to;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [S-1:0] v, input logic [S-1:0] l,
                                input logic [2*S-1:0] d, input logic rd, input logic egv,
                                input logic cg, input logic [1:0] eg, input logic eto);
        vec_t t;
        t.rst = r; t.valid = v; t.last = l; t.dest = d; t.ready = rd;
        t.exp_gv = egv; t.chk_g = cg; t.exp_g = eg; t.exp_to = eto;
        return t;
    endfunction

    // Reference model: owner index (-1 when the port is free), rotating priority start, stall count.
    int m_owner, m_ptr, m_cnt;
    bit m_to;

    function automatic int rr_pick(input logic [S-1:0] c, input int from);
        for (int k = 0; k < S; k++) begin
            if (c[(from + k) % S]) return (from + k) % S;
        end
        return -1;
    endfunction

    function automatic void model_step();
        logic [S-1:0] r;
        bit b, done, tmo;
        for (int i = 0; i < S; i++) r[i] = valid[i] && (int'(dest[i]) == P);
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            m_owner = rr_pick(r, m_ptr);
            m_cnt   = 0;
        end else begin
            b    = valid[m_owner] && ready;
            done = b && last[m_owner];
            tmo  = TO_EN && !b && (m_cnt == TO_CYC - 1);
            if (done || tmo) begin
                m_ptr = (m_owner + 1) % S;
                r[m_owner] = 1'b0;
                m_owner = rr_pick(r, m_ptr);
                m_cnt = 0;
                m_to  = tmo;
            end else begin
                m_cnt = b ? 0 : m_cnt + 1;
            end
        end
    endfunction

    initial begin
        vec_t vecs[$];
        int   exp_seq [12] = '{0, 0, 1, 1, 3, 3, 0, 0, 1, 1, 3, 3};
        int   pb [S];
        bit   bt [S];
        int   stall_len;

        rst = 1'b1;
        drive_idle();

        // Reset/idle, a 3-beat packet from stream 2, dest filter, then reset mid-packet.
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 8'h00, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 8'h00, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 8'h10, 1, 1, 1, 2, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 8'h10, 1, 1, 1, 2, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 8'h10, 1, 1, 1, 2, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 8'h10, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 8'h02, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 8'h02, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 8'h03, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 8'h03, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 8'h10, 1, 1, 1, 2, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 8'h10, 1, 1, 1, 2, 0));
        vecs.push_back(mk(1, 4'b0100, 4'b0000, 8'h10, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 0, 0));

        foreach (vecs[n]) begin
            rst   = vecs[n].rst;
            valid = vecs[n].valid;
            last  = vecs[n].last;
            ready = vecs[n].ready;
            for (int i = 0; i < S; i++) dest[i] = vecs[n].dest[2*i +: 2];
            cycle();
            check($sformatf("vec%0d_gv", n), gv, vecs[n].exp_gv);
            if (vecs[n].chk_g) check($sformatf("vec%0d_grant", n), grant, vecs[n].exp_g);
            check($sformatf("vec%0d_to", n), to, vecs[n].exp_to);
        end

        // Round robin among streams 0, 1, 3 with back-to-back 2-beat packets.
        do_reset();
        valid = 4'b1011;
        for (int i = 0; i < S; i++) begin
            dest[i] = 2'd1;
            pb[i]   = 0;
        end
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < S; i++) begin
                last[i] = (pb[i] == 1);
                bt[i]   = gv && (int'(grant) == i) && ready && valid[i];
            end
            cycle();
            for (int i = 0; i < S; i++) if (bt[i]) pb[i] = (pb[i] + 1) % 2;
            check($sformatf("rr%0d_gv", c), gv, 1);
            check($sformatf("rr%0d_grant", c), grant, exp_seq[c]);
        end

        // Backpressure: owner holds the port while stream 3 waits.
        do_reset();
        valid   = 4'b0001;
        dest[0] = 2'd1;
        cycle();
        check("bp_first_grant", grant, 0);
        cycle();
        check("bp_after_beat", grant, 0);
        ready   = 1'b0;
        valid   = 4'b1001;
        dest[3] = 2'd1;
        stall_len = TO_EN ? TO_CYC - 2 : 10;
        for (int c = 0; c < stall_len; c++) begin
            cycle();
            check($sformatf("bp_hold%0d_gv", c), gv, 1);
            check($sformatf("bp_hold%0d_grant", c), grant, 0);
        end
        ready = 1'b1;
        last  = 4'b0001;
        cycle();
        check("bp_handover_grant", grant, 3);
        check("bp_handover_gv", gv, 1);
        drive_idle();

`ifdef STREAM_ARB_TIMEOUT_EN
        // Owner stalls with valid low while stream 1 requests.
        do_reset();
        valid   = 4'b0001;
        dest[0] = 2'd1;
        cycle();
        check("to_first_grant", grant, 0);
        valid   = 4'b0010;
        dest[1] = 2'd1;
        for (int k = 1; k <= TO_CYC; k++) begin
            cycle();
            check($sformatf("to_stall%0d_pulse", k), to, (k == TO_CYC));
            check($sformatf("to_stall%0d_grant", k), grant, (k == TO_CYC) ? 1 : 0);
        end
        cycle();
        check("to_pulse_drop", to, 0);
        drive_idle();
`endif

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst   = (c == 0) || ($urandom_range(0, 199) == 0);
            ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < S; i++) begin
                valid[i] = ($urandom_range(0, 3) != 0);
                last[i]  = ($urandom_range(0, 2) == 0);
                dest[i]  = 2'($urandom_range(0, 3));
            end
            model_step();
            cycle();
            check("rand_gv", gv, (m_owner >= 0));
            if (m_owner >= 0) check("rand_grant", grant, m_owner);
            check("rand_to", to, m_to);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_port_arbiter.md
Name: stream_port_arbiter

Overview:
- Packet-level round-robin arbiter for one output port of the stream crossbar; one instance per output port.
- Selects which input stream owns output port PORT_IDX and holds that ownership until the granted packet's last beat is accepted.
- Drives the grant index and grant-valid consumed by the crossbar data network.

Parameters:
- S_DATA_COUNT, 2, number of input (slave) streams competing for this port
- M_DATA_COUNT, 3, number of output ports in the crossbar; sets the dest width
- PORT_IDX, 0, index of the output port this instance arbitrates (0..M_DATA_COUNT-1)
- TIMEOUT_CYCLES, 256, stall-cycle limit before a forced release (used only with the optional feature)
- T_ID___WIDTH (localparam), max(1, clog2(S_DATA_COUNT)), width of the grant index
- T_DEST_WIDTH (localparam), max(1, clog2(M_DATA_COUNT)), width of each dest field

Ports:
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, synchronous, active-high
- s_dest_i  in  T_DEST_WIDTH x S_DATA_COUNT (unpacked)  destination of each input stream
- s_valid_i  in  S_DATA_COUNT  input valids
- s_last_i  in  S_DATA_COUNT  input last flags
- m_ready_i  in  1  ready of output port PORT_IDX
- grant_o  out  T_ID___WIDTH  index of the owning input stream
- grant_valid_o  out  1  port currently owned; grant_o is meaningful only while this is high
- timeout_o  out  1  one-cycle pulse on a forced release

Behaviour:
- Reset (clk_i edge with rst_i=1): state IDLE, grant_o=0, grant_valid_o=0, timeout_o=0, RR pointer=0. This applies mid-packet as well; the packet is abandoned with no further handshake.
- Request vector: req[i] = s_valid_i[i] && (s_dest_i[i] == PORT_IDX). A dest value >= M_DATA_COUNT never matches.
- RR pick: the first set bit of the candidate vector, searching from the pointer upward and wrapping S_DATA_COUNT-1 -> 0.
- States: IDLE, LOCKED. All outputs are registered.
- IDLE:
  - If req != 0: load grant_o = pick(req), set grant_valid_o=1, go to LOCKED.
  - Arbitration latency is 1 cycle: the request is seen in cycle N and the grant is visible in cycle N+1.
- LOCKED:
  - beat = s_valid_i[g] && m_ready_i, where g = grant_o.
  - On beat && s_last_i[g]: the pointer becomes (g+1) mod S_DATA_COUNT. Then re-arbitrate in the same edge among req with bit g masked.
    - If a candidate exists, load the new grant and stay LOCKED. There are no idle cycles between packets.
    - Otherwise set grant_valid_o=0 and go to IDLE.
  - Requester g competes again from the following cycle.
  - Changes to s_dest_i or requests from other streams while LOCKED have no effect.
- Simultaneous requests: the RR pointer fully decides the order. Each requester waits at most S_DATA_COUNT-1 packets.
- S_DATA_COUNT=1: the pointer stays 0 and the block grants stream 0 whenever req[0]=1.

Optional Feature:
- Macro: STREAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in LOCKED, clears on every beat and on every new grant, and increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES-1 with no beat, the arbiter force-releases: timeout_o=1 for one cycle, the pointer advances to g+1, and it re-arbitrates exactly as on a last beat.
  - Counter width is clog2(TIMEOUT_CYCLES)+1. The counter resets to 0.
- Undefined: no counter is built, timeout_o is tied to 0, and the port list is unchanged.

Decomposition:
- Package stream_xbar_pkg:
  - arb_state_t enum {IDLE, LOCKED}
  - width helper function for the max(1, clog2()) localparams
- Sub-module stream_rr_picker: combinational pick from a request vector and a pointer, returning index and found flag. It is reused by the crossbar arbiters unit.

Test Plan:
- Reset and idle:
  - Stimulus: rst_i=1 for 2 cycles, then s_valid_i=0.
  - Required: grant_valid_o=0, grant_o=0, timeout_o=0 on every cycle.
- Single packet (S=4, M=3, PORT_IDX=1):
  - Stimulus: stream 2 sends dest=1 with a 3-beat packet and m_ready_i=1.
  - Required: grant_o=2 with grant_valid_o=1 one cycle after valid, held through the beat with last=1. grant_valid_o falls the cycle after that beat.
- Round-robin fairness:
  - Stimulus: streams 0, 1 and 3 all hold dest=1 with continuous 2-beat packets.
  - Required: grant sequence 0, 1, 3, 0, 1, 3 with no idle cycle between packets.
- Backpressure and lock:
  - Stimulus: m_ready_i=0 for 10 cycles mid-packet while stream 3 raises a request.
  - Required: grant_o stays at the owner. Stream 3 is granted only after the owner's last beat.
- Dest filter and reset mid-packet:
  - Stimulus: stream 0 uses dest=2 or dest=3; separately, rst_i is pulsed during a LOCKED packet.
  - Required: no grant for either dest value. The reset pulse gives grant_valid_o=0 on the next edge.
- Timeout (macro defined, TIMEOUT_CYCLES=8):
  - Stimulus: the owner stalls with s_valid_i=0 while stream 1 is requesting.
  - Required: timeout_o pulses after 8 stall cycles, and grant_o=1 on the same edge.
